// File: rtl/fir_pkg.sv
// Shared types, Q1.15 constants and the round/saturate helper for the serial FIR equalizer.
package fir_pkg;

   typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} fir_state_t;

   localparam logic signed [15:0] Q15_MAX    = 16'sh7FFF;
   localparam logic signed [15:0] Q15_MIN    = 16'sh8000;
   localparam int                 ROUND_HALF = 2**14;

   // Wide enough to hold any accumulator this engine can be built with.
   localparam int unsigned SAT_W = 64;

   // Round half up from Q2.30-scaled accumulator to Q1.15, then clip.
   function automatic logic signed [15:0] sat_q15(input logic signed [SAT_W-1:0] acc);
      logic signed [SAT_W-1:0] r;
      r = (acc + SAT_W'(ROUND_HALF)) >>> 15;
      if (r > SAT_W'(Q15_MAX))
         return Q15_MAX;
      else if (r < SAT_W'(Q15_MIN))
         return Q15_MIN;
      else
         return r[15:0];
   endfunction

endpackage

// File: rtl/fir_serial_eq_if.sv
// Sample stream, result stream and coefficient write port of the serial FIR equalizer.
interface fir_serial_eq_if #(
   parameter int unsigned TAPS = 8,
   parameter int unsigned DW   = 16
);
   localparam int unsigned KW = $clog2(TAPS);

   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_data;
   logic                 coef_we;
   logic [KW-1:0]        coef_addr;
   logic signed [DW-1:0] coef_data;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] out_data;

   modport master (
      output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
module fir_mac #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 35
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic signed [AW-1:0] acc
);
   logic signed [2*DW-1:0] prod_c;

   assign prod_c = a * b;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + AW'(prod_c);
   end
endmodule

// File: rtl/fir_serial_eq.sv
// Time-multiplexed FIR tap engine: one sample in, TAPS serial MACs, one rounded Q1.15 sample out.
module fir_serial_eq
   import fir_pkg::*;
#(
   parameter int unsigned TAPS = 8,
   parameter int unsigned DW   = 16
) (
   input  logic           clk,
   input  logic           rst,
   fir_serial_eq_if.slave bus,
   output logic           busy
);
   localparam int unsigned KW = $clog2(TAPS);
   localparam int unsigned AW = 2*DW + KW;

   fir_state_t           state, state_nxt;
   logic [KW-1:0]        k_q;
   logic signed [DW-1:0] x_q [TAPS];
   logic signed [DW-1:0] h_q [TAPS];
   logic                 mac_clr, mac_en, accept;
   logic signed [AW-1:0] acc;

   assign accept = (state == IDLE) && bus.in_valid;

   // Next-state and MAC control.
   always_comb begin
      state_nxt = state;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               mac_clr   = 1'b1;
               state_nxt = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (k_q == KW'(TAPS-1))
               state_nxt = ROUND;
         end
         ROUND: state_nxt = OUT;
         OUT: begin
            if (bus.out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         k_q           <= '0;
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
         bus.in_ready  <= 1'b1;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         k_q           <= (state == MAC) ? k_q + KW'(1) : '0;
         bus.out_valid <= (state_nxt == OUT);
         bus.in_ready  <= (state_nxt == IDLE);
         busy          <= (state_nxt != IDLE);
         if (state == ROUND)
            bus.out_data <= DW'(sat_q15(SAT_W'(acc)));
      end
   end

   // Delay line and coefficient bank; both only change while idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
            h_q[i] <= '0;
         end
      end else if (state == IDLE) begin
         if (accept) begin
            x_q[0] <= bus.in_data;
            for (int i = 1; i < TAPS; i++)
               x_q[i] <= x_q[i-1];
         end
         if (bus.coef_we)
            h_q[bus.coef_addr] <= bus.coef_data;
      end
   end

   fir_mac #(.DW(DW), .AW(AW)) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (x_q[k_q]),
      .b   (h_q[k_q]),
      .acc (acc)
   );
endmodule
